// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type, default sizes and saturation constant for bcd_convert_seq.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_BIN_W = 18;
  localparam int BCD_DIGITS = 5;
  function automatic logic [63:0] all_nines(input int digits);
    all_nines = '0;
    for (int i = 0; i < digits; i++) all_nines[4*i +: 4] = 4'h9;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble digit cell, adds 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Define BCD_SEQ_SAT_EN to saturate bcd to all-nines when ovf is set.
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = BCD_BIN_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int CW = $clog2(BIN_W);
  localparam int SW = 4 * (DIGITS + 1);
  localparam int OW = 4 * DIGITS;
`ifdef BCD_SEQ_SAT_EN
  localparam logic [OW-1:0] SAT = OW'(all_nines(DIGITS));
`endif
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [SW-1:0]   scr_q, scr_d, adj;
  logic [OW-1:0]   bcd_q, bcd_d, res;
  logic            ovf_q, ovf_d, done_q, done_d, top_nz;
  for (genvar i = 0; i <= DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(scr_q[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  assign ready = state_q != SHIFT;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
  // the scratch carries one spare digit, so its msb never sets and rotating it back in equals shifting in 0
  always_comb begin
    top_nz = scr_q[SW-1 -: 4] != 4'd0;
`ifdef BCD_SEQ_SAT_EN
    res = top_nz ? SAT : scr_q[OW-1:0];
`else
    res = scr_q[OW-1:0];
`endif
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    scr_d = scr_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    done_d = state_q == DONE;
    if (state_q == DONE) begin
      bcd_d = res;
      ovf_d = top_nz;
      state_d = IDLE;
    end
    if (state_q == SHIFT) begin
      {scr_d, sh_d} = {adj[SW-2:0], sh_q, adj[SW-1]};
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(BIN_W - 1)) ? DONE : SHIFT;
    end else if (start) begin
      sh_d = bin;
      scr_d = '0;
      cnt_d = '0;
      state_d = SHIFT;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      scr_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      scr_q <= scr_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
endmodule
